mult_booth_unit: RTL and testbench
==================================

// Module: mult_booth_unit
// PURPOSE
//   Multicycle signed 32x32 multiplier for the MULT instruction, using radix-2 Booth.
//   Sits downstream of the control unit. It takes operands from the A and B registers
//   and a one-cycle start pulse (mult_control).
//   It returns a 64-bit product split into HI and LO, which feed the HI/LO registers.
//   A one-cycle mult_end pulse tells the control unit when to write HI/LO.
// PARAMETERS
//   WIDTH  32  operand width; product is 2*WIDTH bits (hi_out = upper, lo_out = lower)
// PORTS
//   clk           in   1      system clock, rising edge
//   reset_in      in   1      reset, asynchronous, active-low (0 = reset)
//   mult_control  in   1      start pulse; sampled only in IDLE
//   a_in          in   WIDTH  multiplicand (from A reg), signed two's complement
//   b_in          in   WIDTH  multiplier (from B reg), signed two's complement
//   hi_out        out  WIDTH  product[2*WIDTH-1:WIDTH]
//   lo_out        out  WIDTH  product[WIDTH-1:0]
//   mult_end      out  1      one-cycle done pulse; hi_out/lo_out valid while high
//   busy          out  1      1 in RUN and DONE states
// BEHAVIOUR
//   Reset (reset_in=0, any time, including mid-operation):
//   - state=IDLE; acc, m, q, q_m1, count = 0; hi_out=lo_out=0; mult_end=0; busy=0.
//   - Any in-flight operation is discarded; no mult_end pulse follows.
//   Internal registers:
//   - acc and m: WIDTH+1 bits, sign-extended, so a multiplicand of -2^(WIDTH-1) is exact.
//   - q: WIDTH bits. q_m1: 1 bit. count: $clog2(WIDTH+1) bits.
//   FSM: IDLE -> RUN -> DONE -> IDLE.
//   IDLE:
//   - If mult_control=1: m<=sext(a_in), q<=b_in, acc<=0, q_m1<=0, count<=WIDTH; go to RUN.
//   - Otherwise hold. hi_out and lo_out keep their last result indefinitely.
//   RUN: one Booth iteration per clock.
//   - {q[0],q_m1}=01: t=acc+m. =10: t=acc-m. =00 or 11: t=acc.
//   - Arithmetic shift right: {acc,q,q_m1} <= {t[WIDTH],t,q}.
//   - count <= count-1. When count==1 at this edge (last iteration), go to DONE.
//   DONE:
//   - hi_out<=acc[WIDTH-1:0], lo_out<=q, mult_end<=1, go to IDLE.
//   - mult_end is registered. It is high for exactly one cycle and cleared at the next edge.
//   Latency:
//   - Start sampled at edge E0; iterations run at E1..E_WIDTH; outputs and pulse update at E_WIDTH+1.
//   - mult_end is high in the cycle following E_WIDTH+1 (WIDTH+1 cycles after start).
//   Handshake and boundaries:
//   - mult_control while busy=1 (RUN or DONE) is ignored. The operand inputs are not resampled.
//   - a_in and b_in are sampled only at the accepting edge and may change freely afterwards.
//   - mult_control may be high in the same cycle mult_end is high (state is IDLE then).
//     It is accepted, starting a new operation back-to-back. hi_out/lo_out hold the previous
//     result until the new DONE.
//   - mult_control held high continuously restarts immediately after each completion.
//   - Arithmetic is exact for all signed inputs, with no overflow flag. The product of
//     -2^(WIDTH-1) and -2^(WIDTH-1) is 2^(2*WIDTH-2), which fits in 2*WIDTH signed bits.
// TESTING
//   - Basic timing: a=3, b=5, 1-cycle start.
//     -> mult_end after exactly 33 cycles; hi=0x00000000, lo=0x0000000F.
//   - Mixed sign: a=-7 (0xFFFFFFF9), b=6.
//     -> hi=0xFFFFFFFF, lo=0xFFFFFFD6. Also check a=6, b=-7 gives the same result.
//   - Corner values:
//     -> a=b=0x80000000 gives hi=0x40000000, lo=0x00000000.
//     -> a=b=0xFFFFFFFF gives hi=0, lo=1.
//     -> a=0x7FFFFFFF, b=2 gives hi=0, lo=0xFFFFFFFE.
//   - Start while busy: start 3*5, pulse mult_control with a=9 at cycle 10.
//     -> ignored; result stays 15; exactly one mult_end pulse.
//   - Back-to-back: assert start (a=2, b=2) in the mult_end cycle of 3*5.
//     -> second mult_end 33 cycles later with lo=4; lo holds 15 in between.
//   - Reset mid-op: reset_in=0 asynchronously at cycle 12 of a run.
//     -> outputs 0 immediately, busy=0, no mult_end.
//     -> a new start after release completes normally.

Source files
------------

// File: rtl/mult_booth_unit_if.sv
// Operand/result bundle between the control unit (master) and the Booth multiplier (slave).
// mult_control is a start strobe taken only while busy is low; hi_out/lo_out are valid while mult_end is high.
interface mult_booth_unit_if #(
    parameter int WIDTH = 32
);
    logic             mult_control;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             mult_end;
    logic             busy;

    modport master (
        output mult_control, a_in, b_in,
        input  hi_out, lo_out, mult_end, busy
    );

    modport slave (
        input  mult_control, a_in, b_in,
        output hi_out, lo_out, mult_end, busy
    );
endinterface

// File: rtl/mult_booth_unit.sv
// Multicycle signed WIDTHxWIDTH radix-2 Booth multiplier: one iteration per clock,
// 2*WIDTH-bit product split into HI/LO with a registered one-cycle mult_end pulse.
module mult_booth_unit #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset_in,
    mult_booth_unit_if.slave    bus,
    output logic [1:0]          fsm_state
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   m;
    logic [WIDTH-1:0] q;
    logic             q_m1;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   t;

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             end_q;

    logic             start;
    logic             last;
    logic             busy;

    // State register
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.mult_control) state_next = RUN;
            RUN:     if (count == CW'(1))  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM decoded outputs
    always_comb begin
        start = 1'b0;
        last  = 1'b0;
        busy  = 1'b0;
        case (state)
            IDLE:    start = bus.mult_control;
            RUN:     begin
                busy = 1'b1;
                last = (count == CW'(1));
            end
            DONE:    busy = 1'b1;
            default: ;
        endcase
    end

    // Booth step: {q[0], q_m1} selects add, subtract or pass of the multiplicand
    always_comb begin
        t = acc;
        case ({q[0], q_m1})
            2'b01:   t = acc + m;
            2'b10:   t = acc - m;
            default: t = acc;
        endcase
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            acc   <= '0;
            m     <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            count <= '0;
        end else if (start) begin
            m     <= {bus.a_in[WIDTH-1], bus.a_in};
            q     <= bus.b_in;
            acc   <= '0;
            q_m1  <= 1'b0;
            count <= CW'(WIDTH);
        end else if (state == RUN) begin
            {acc, q, q_m1} <= {t[WIDTH], t, q};
            count          <= count - CW'(1);
        end
    end

    // Result registers hold the last product until the next DONE
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            hi_q  <= '0;
            lo_q  <= '0;
            end_q <= 1'b0;
        end else begin
            end_q <= (state == DONE);
            if (state == DONE) begin
                hi_q <= acc[WIDTH-1:0];
                lo_q <= q;
            end
        end
    end

    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;
    assign bus.mult_end = end_q;
    assign bus.busy     = busy;
    assign fsm_state    = state;

    logic unused_last;
    assign unused_last = last;
endmodule

// File: tb/tb_mult_booth_unit.sv
// Directed bench for mult_booth_unit: product table plus timing, busy, back-to-back and reset sequences.
module tb_mult_booth_unit;
    localparam int WIDTH = 32;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic       clk;
    logic       reset_in;
    logic [1:0] fsm_state;

    mult_booth_unit_if #(.WIDTH(WIDTH)) bus ();

    mult_booth_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_in  (reset_in),
        .bus       (bus.slave),
        .fsm_state (fsm_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];
    vec_t vecs[11];

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver: present operands and a one-cycle start; returns right after the accepting edge
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.a_in = a;
        bus.b_in = b;
        bus.mult_control = 1'b1;
        @(posedge clk);
        #1;
        bus.mult_control = 1'b0;
    endtask

    // Counts edges after the accepting edge until mult_end is seen; -1 on timeout
    task automatic wait_end(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.mult_end) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic score(input string name);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_queue"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check(name, {bus.hi_out, bus.lo_out}, e);
        end
    endtask

    initial begin
        int n;
        int pulses;
        int first_end;
        int second_end;
        bit hold_ok;

        vecs[0]  = '{32'd3,        32'd5,        32'h00000000, 32'h0000000F};
        vecs[1]  = '{32'hFFFFFFF9, 32'd6,        32'hFFFFFFFF, 32'hFFFFFFD6};
        vecs[2]  = '{32'd6,        32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFD6};
        vecs[3]  = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[5]  = '{32'h7FFFFFFF, 32'd2,        32'h00000000, 32'hFFFFFFFE};
        vecs[6]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[7]  = '{32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000};
        vecs[8]  = '{32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
        vecs[9]  = '{32'h12345678, 32'd1,        32'h00000000, 32'h12345678};
        vecs[10] = '{32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'h80000000};

        bus.mult_control = 1'b0;
        bus.a_in = '0;
        bus.b_in = '0;
        reset_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hi_lo", {bus.hi_out, bus.lo_out}, 64'd0);
        check("reset_end_busy", {62'd0, bus.mult_end, bus.busy}, 64'd0);
        check("reset_state", {62'd0, fsm_state}, 64'd0);
        @(negedge clk);
        reset_in = 1'b1;

        // Table of products, each with latency and pulse-width checks
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back({vecs[i].hi, vecs[i].lo});
            start_op(vecs[i].a, vecs[i].b);
            check($sformatf("busy_v%0d", i), {63'd0, bus.busy}, 64'd1);
            bus.a_in = 32'hDEADBEEF;
            bus.b_in = 32'hCAFEF00D;
            wait_end(n);
            check($sformatf("latency_v%0d", i), 64'(n), 64'd33);
            score($sformatf("product_v%0d", i));
            @(posedge clk);
            #1;
            check($sformatf("end_width_v%0d", i), {63'd0, bus.mult_end}, 64'd0);
            check($sformatf("hold_v%0d", i), {bus.hi_out, bus.lo_out}, {vecs[i].hi, vecs[i].lo});
        end

        // Start while busy is ignored
        exp_q.push_back(64'd15);
        start_op(32'd3, 32'd5);
        pulses = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 10) begin
                bus.a_in = 32'd9;
                bus.mult_control = 1'b1;
            end else begin
                bus.mult_control = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.mult_end) begin
                pulses++;
                if (pulses == 1) score("busy_ignore_product");
            end
        end
        bus.mult_control = 1'b0;
        check("busy_ignore_pulses", 64'(pulses), 64'd1);
        check("busy_ignore_hold", {bus.hi_out, bus.lo_out}, 64'd15);

        // Back-to-back start in the mult_end cycle
        exp_q.push_back(64'd15);
        start_op(32'd3, 32'd5);
        wait_end(n);
        check("b2b_first_latency", 64'(n), 64'd33);
        score("b2b_first_product");
        bus.a_in = 32'd2;
        bus.b_in = 32'd2;
        bus.mult_control = 1'b1;
        @(posedge clk);
        #1;
        bus.mult_control = 1'b0;
        hold_ok = 1'b1;
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.mult_end) begin
                n = i;
                break;
            end
            if (bus.lo_out !== 32'd15) hold_ok = 1'b0;
        end
        check("b2b_second_latency", 64'(n), 64'd33);
        check("b2b_hold_lo", {63'd0, hold_ok}, 64'd1);
        check("b2b_second_product", {bus.hi_out, bus.lo_out}, 64'd4);

        // mult_control held high restarts right after each completion
        @(negedge clk);
        bus.a_in = 32'd5;
        bus.b_in = 32'd5;
        bus.mult_control = 1'b1;
        first_end = -1;
        second_end = -1;
        for (int c = 1; c <= 120; c++) begin
            @(posedge clk);
            #1;
            if (bus.mult_end) begin
                if (first_end < 0) first_end = c;
                else if (second_end < 0) second_end = c;
            end
        end
        bus.mult_control = 1'b0;
        check("held_start_spacing", 64'(second_end - first_end), 64'd34);
        check("held_start_product", {bus.hi_out, bus.lo_out}, 64'd25);
        repeat (40) @(posedge clk);

        // Asynchronous reset mid-operation
        start_op(32'd3, 32'd5);
        repeat (11) @(posedge clk);
        #3;
        reset_in = 1'b0;
        #1;
        check("midreset_hi_lo", {bus.hi_out, bus.lo_out}, 64'd0);
        check("midreset_end_busy", {62'd0, bus.mult_end, bus.busy}, 64'd0);
        check("midreset_state", {62'd0, fsm_state}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_in = 1'b1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.mult_end) pulses++;
        end
        check("midreset_no_end", 64'(pulses), 64'd0);
        exp_q.push_back(64'd6);
        start_op(32'd2, 32'd3);
        wait_end(n);
        check("post_reset_latency", 64'(n), 64'd33);
        score("post_reset_product");

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
